// File: rtl/nabp_processing_scan_controller.sv
// -----------------------------------------------------------------------------
// nabp_processing_scan_controller
//
// Sequences the processing swappables for one projection angle at a time.
// An angle is accepted from the host over a valid/ready handshake. Every line
// iteration of the partition is then walked in turn:
//   1. wait for the filtered RAM swappable to report line_ready,
//   2. pulse pe_kick for one cycle,
//   3. drive pe_en and the scan iterator for exactly pImageSize enabled cycles.
// The scan mode and direction are derived from the angle when it is accepted.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   hs_angle_valid/_ready   host angle handshake
//   hs_angle                angle in whole degrees
//   line_ready              filtered RAM holds data for the current line
//   pe_stall                downstream back-pressure, holds the scan
//   tt_angle                latched angle
//   tt_line_itr             current line iteration
//   tt_scan_itr             current scan position
//   tt_scan_mode            0 = x scan, 1 = y scan
//   tt_scan_dir             1 = ascending, 0 = descending
//   pe_kick                 one-cycle start pulse per line
//   pe_en                   scan step valid
//   busy, done              angle in progress / one-cycle completion pulse
//   perf_stall_cnt          stall-cycle counter
//
// Optional feature macro: NABP_SCAN_PERF_COUNT_EN
//   Defined   - perf_stall_cnt counts WAIT_LINE cycles with line_ready low
//               plus SCAN cycles with pe_stall high. Cleared on accept,
//               saturating, held after done.
//   Undefined - perf_stall_cnt is tied to zero.
// -----------------------------------------------------------------------------
module nabp_processing_scan_controller #(
    parameter int pImageSize           = 128,
    parameter int pImageSizeLength     = 7,
    parameter int pPartitionSize       = 16,
    parameter int pPartitionSizeLength = 4,
    parameter int pAngleLength         = 8,
    parameter int pAngle45             = 45,
    parameter int pAngle90             = 90,
    parameter int pAngle135            = 135
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            hs_angle_valid,
    input  logic [pAngleLength-1:0]         hs_angle,
    output logic                            hs_angle_ready,
    input  logic                            line_ready,
    input  logic                            pe_stall,
    output logic [pAngleLength-1:0]         tt_angle,
    output logic [pPartitionSizeLength-1:0] tt_line_itr,
    output logic [pImageSizeLength-1:0]     tt_scan_itr,
    output logic                            tt_scan_mode,
    output logic                            tt_scan_dir,
    output logic                            pe_kick,
    output logic                            pe_en,
    output logic                            busy,
    output logic                            done,
    output logic [31:0]                     perf_stall_cnt
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_LINE = 3'd1;
    localparam logic [2:0] S_KICK      = 3'd2;
    localparam logic [2:0] S_SCAN      = 3'd3;
    localparam logic [2:0] S_NEXT_LINE = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    // Remaining-step counter needs one extra bit to hold pImageSize itself.
    localparam int CW = pImageSizeLength + 1;

    localparam logic [pAngleLength-1:0]         ANGLE_45   = pAngleLength'(pAngle45);
    localparam logic [pAngleLength-1:0]         ANGLE_90   = pAngleLength'(pAngle90);
    localparam logic [pAngleLength-1:0]         ANGLE_135  = pAngleLength'(pAngle135);
    localparam logic [pPartitionSizeLength-1:0] LINE_FIRST = pPartitionSizeLength'(0);
    localparam logic [pPartitionSizeLength-1:0] LINE_LAST  = pPartitionSizeLength'(pPartitionSize - 1);
    localparam logic [pPartitionSizeLength-1:0] LINE_ONE   = pPartitionSizeLength'(1);
    localparam logic [pImageSizeLength-1:0]     SCAN_LOW   = pImageSizeLength'(0);
    localparam logic [pImageSizeLength-1:0]     SCAN_HIGH  = pImageSizeLength'(pImageSize - 1);
    localparam logic [pImageSizeLength-1:0]     SCAN_ONE   = pImageSizeLength'(1);
    localparam logic [CW-1:0]                   REM_FULL   = CW'(pImageSize);
    localparam logic [CW-1:0]                   REM_ONE    = CW'(1);

    logic [2:0]                      state_q, state_d;
    logic [pAngleLength-1:0]         angle_q, angle_d;
    logic [pPartitionSizeLength-1:0] line_q, line_d;
    logic [pImageSizeLength-1:0]     scan_q, scan_d;
    logic [CW-1:0]                   rem_q, rem_d;
    logic                            mode_q, mode_d;
    logic                            dir_q, dir_d;
    logic                            ready_q, busy_q, kick_q, done_q;
    logic                            accept_s;

    assign accept_s = (state_q == S_IDLE) && hs_angle_valid && ready_q;

    // Next-state and datapath decode for the scan sequencer.
    always_comb begin
        state_d = state_q;
        angle_d = angle_q;
        line_d  = line_q;
        scan_d  = scan_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    angle_d = hs_angle;
                    mode_d  = (hs_angle >= ANGLE_45) && (hs_angle < ANGLE_135);
                    dir_d   = (hs_angle < ANGLE_90);
                    line_d  = LINE_FIRST;
                    state_d = S_WAIT_LINE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_LINE: begin
                if (line_ready) begin
                    state_d = S_KICK;
                end else begin
                    state_d = S_WAIT_LINE;
                end
            end
            S_KICK: begin
                scan_d  = dir_q ? SCAN_LOW : SCAN_HIGH;
                rem_d   = REM_FULL;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (!pe_stall) begin
                    rem_d = rem_q - REM_ONE;
                    // The final step leaves the iterator on its last value so
                    // it never leaves the 0..pImageSize-1 range.
                    if (rem_q == REM_ONE) begin
                        state_d = S_NEXT_LINE;
                    end else begin
                        scan_d = dir_q ? (scan_q + SCAN_ONE) : (scan_q - SCAN_ONE);
                    end
                end else begin
                    state_d = S_SCAN;
                end
            end
            S_NEXT_LINE: begin
                if (line_q == LINE_LAST) begin
                    state_d = S_DONE;
                end else begin
                    line_d  = line_q + LINE_ONE;
                    state_d = S_WAIT_LINE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and registered status outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            angle_q <= {pAngleLength{1'b0}};
            line_q  <= {pPartitionSizeLength{1'b0}};
            scan_q  <= {pImageSizeLength{1'b0}};
            rem_q   <= {CW{1'b0}};
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            kick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            angle_q <= angle_d;
            line_q  <= line_d;
            scan_q  <= scan_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            ready_q <= (state_d == S_IDLE);
            busy_q  <= (state_d == S_WAIT_LINE) || (state_d == S_KICK) ||
                       (state_d == S_SCAN) || (state_d == S_NEXT_LINE);
            kick_q  <= (state_d == S_KICK);
            done_q  <= (state_d == S_DONE);
        end
    end

    // pe_en must react to pe_stall in the same cycle, so it is not registered.
    assign pe_en          = (state_q == S_SCAN) && !pe_stall;
    assign hs_angle_ready = ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pe_kick        = kick_q;
    assign tt_angle       = angle_q;
    assign tt_line_itr    = line_q;
    assign tt_scan_itr    = scan_q;
    assign tt_scan_mode   = mode_q;
    assign tt_scan_dir    = dir_q;

`ifdef NABP_SCAN_PERF_COUNT_EN
    logic [31:0] perf_q, perf_d;
    logic        stall_cycle_s;

    assign stall_cycle_s = ((state_q == S_WAIT_LINE) && !line_ready) ||
                           ((state_q == S_SCAN) && pe_stall);

    // Stall counter: cleared on accept, saturating, otherwise held.
    always_comb begin
        perf_d = perf_q;
        if (accept_s) begin
            perf_d = 32'd0;
        end else if (stall_cycle_s && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end else begin
            perf_d = perf_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_nabp_processing_scan_controller.sv
// -----------------------------------------------------------------------------
// Bench for nabp_processing_scan_controller (pImageSize=8, pPartitionSize=4).
// Each angle is driven phase by phase (wait, kick, scan, next line, done); the
// expected outputs of every cycle come from the angle rules and the step count.
// -----------------------------------------------------------------------------
module tb_nabp_processing_scan_controller;

    localparam int P  = 8;
    localparam int NL = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        hs_angle_valid = 1'b0;
    logic [7:0]  hs_angle = 8'd0;
    logic        hs_angle_ready;
    logic        line_ready = 1'b0;
    logic        pe_stall = 1'b0;
    logic [7:0]  tt_angle;
    logic [1:0]  tt_line_itr;
    logic [2:0]  tt_scan_itr;
    logic        tt_scan_mode;
    logic        tt_scan_dir;
    logic        pe_kick;
    logic        pe_en;
    logic        busy;
    logic        done;
    logic [31:0] perf_stall_cnt;

    nabp_processing_scan_controller #(
        .pImageSize(8), .pImageSizeLength(3),
        .pPartitionSize(4), .pPartitionSizeLength(2),
        .pAngleLength(8), .pAngle45(45), .pAngle90(90), .pAngle135(135)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .hs_angle_valid(hs_angle_valid), .hs_angle(hs_angle),
        .hs_angle_ready(hs_angle_ready),
        .line_ready(line_ready), .pe_stall(pe_stall),
        .tt_angle(tt_angle), .tt_line_itr(tt_line_itr), .tt_scan_itr(tt_scan_itr),
        .tt_scan_mode(tt_scan_mode), .tt_scan_dir(tt_scan_dir),
        .pe_kick(pe_kick), .pe_en(pe_en), .busy(busy), .done(done),
        .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected values held between angles
    int exp_angle = 0;
    int exp_line  = 0;
    int exp_mode  = 0;
    int exp_dir   = 0;
    int perf_acc  = 0;

    // Pulse monitors
    int kick_mon = 0;
    int en_mon   = 0;
    always @(negedge clk) begin
        if (pe_kick) kick_mon <= kick_mon + 1;
        if (pe_en)   en_mon   <= en_mon + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int perf_exp();
`ifdef NABP_SCAN_PERF_COUNT_EN
        return perf_acc;
`else
        return 0;
`endif
    endfunction

    task automatic out_chk(input int kick, input int en, input int bsy, input int dn, input int rdy);
        chk("pe_kick",        32'(pe_kick),        32'(kick));
        chk("pe_en",          32'(pe_en),          32'(en));
        chk("busy",           32'(busy),           32'(bsy));
        chk("done",           32'(done),           32'(dn));
        chk("hs_angle_ready", 32'(hs_angle_ready), 32'(rdy));
        chk("tt_angle",       32'(tt_angle),       32'(exp_angle));
        chk("tt_line_itr",    32'(tt_line_itr),    32'(exp_line));
        chk("tt_scan_mode",   32'(tt_scan_mode),   32'(exp_mode));
        chk("tt_scan_dir",    32'(tt_scan_dir),    32'(exp_dir));
        chk("perf_stall_cnt", perf_stall_cnt,      32'(perf_exp()));
    endtask

    // One complete angle. rnd: random waits/stalls/ignored inputs.
    // hold: keep hs_angle_valid high throughout. abort_line: reset in its scan.
    // w2: line_ready-low cycles before line 2; s1: stall cycles in line 1.
    task automatic run_angle(input int ang, input bit rnd, input bit hold,
                             input int abort_line, input int w2, input int s1);
        int kick0, en0, waits, k, guard, sc, exp_scan;
        bit st;
        kick0 = kick_mon;
        en0   = en_mon;
        // IDLE cycle: angle offered and accepted on the closing edge
        hs_angle_valid = 1'b1;
        hs_angle       = 8'(ang);
        line_ready     = rnd ? 1'($urandom) : 1'b1;
        pe_stall       = rnd ? 1'($urandom) : 1'b0;
        @(negedge clk);
        out_chk(0, 0, 0, 0, 1);
        @(posedge clk); #1;
        exp_angle = ang % 256;
        exp_mode  = (exp_angle >= 45 && exp_angle < 135) ? 1 : 0;
        exp_dir   = (exp_angle < 90) ? 1 : 0;
        exp_line  = 0;
        perf_acc  = 0;
        if (hold) hs_angle = 8'($urandom);
        else hs_angle_valid = 1'b0;
        for (int l = 0; l < NL; l++) begin
            waits = rnd ? int'($urandom_range(0, 3)) : ((l == 2) ? w2 : 0);
            for (int w = 0; w <= waits; w++) begin
                line_ready = (w == waits);
                pe_stall   = rnd ? 1'($urandom) : 1'b0;
                @(negedge clk);
                out_chk(0, 0, 1, 0, 0);
                @(posedge clk); #1;
                if (w < waits) perf_acc++;
                if (hold) hs_angle = 8'($urandom);
            end
            line_ready = rnd ? 1'($urandom) : 1'b1;
            pe_stall   = rnd ? 1'($urandom) : 1'b0;
            @(negedge clk);
            out_chk(1, 0, 1, 0, 0);
            @(posedge clk); #1;
            k = 0; guard = 0; sc = 0;
            while (k < P && guard < 200) begin
                st = rnd ? ($urandom % 4 == 0) : (l == 1 && k == 4 && sc < s1);
                pe_stall   = st;
                line_ready = rnd ? 1'($urandom) : 1'b0;
                exp_scan   = exp_dir ? k : (P - 1 - k);
                @(negedge clk);
                out_chk(0, st ? 0 : 1, 1, 0, 0);
                chk("tt_scan_itr", 32'(tt_scan_itr), 32'(exp_scan));
                if (l == abort_line && k == 3) begin
                    #2 reset_n = 1'b0;
                    #1;
                    exp_angle = 0; exp_line = 0; exp_mode = 0; exp_dir = 0; perf_acc = 0;
                    out_chk(0, 0, 0, 0, 0);
                    chk("tt_scan_itr_rst", 32'(tt_scan_itr), 32'd0);
                    hs_angle_valid = 1'b0; line_ready = 1'b0; pe_stall = 1'b0;
                    @(posedge clk); #1;
                    reset_n = 1'b1;
                    @(negedge clk);
                    chk("ready_after_release", 32'(hs_angle_ready), 32'd0);
                    @(posedge clk); #1;
                    return;
                end
                @(posedge clk); #1;
                if (st) begin perf_acc++; sc++; end
                else k++;
                guard++;
                if (hold) hs_angle = 8'($urandom);
            end
            chk("scan_steps", 32'(k), 32'(P));
            line_ready = rnd ? 1'($urandom) : 1'b0;
            pe_stall   = rnd ? 1'($urandom) : 1'b0;
            @(negedge clk);
            out_chk(0, 0, 1, 0, 0);
            @(posedge clk); #1;
            if (l < NL - 1) exp_line++;
        end
        // DONE cycle
        @(negedge clk);
        out_chk(0, 0, 0, 1, 0);
        @(posedge clk); #1;
        chk("kick_total", 32'(kick_mon - kick0), 32'(NL));
        chk("en_total",   32'(en_mon - en0),     32'(NL * P));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2;
        out_chk(0, 0, 0, 0, 0);
        chk("tt_scan_itr_reset", 32'(tt_scan_itr), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_first_cycle", 32'(hs_angle_ready), 32'd0);
        @(posedge clk); #1;

        // Directed angles, including compare boundaries
        run_angle(30,  1'b0, 1'b0, -1, 0, 0);
        run_angle(100, 1'b0, 1'b0, -1, 0, 0);
        run_angle(135, 1'b0, 1'b0, -1, 0, 0);
        run_angle(44,  1'b0, 1'b0, -1, 0, 0);
        run_angle(45,  1'b0, 1'b0, -1, 0, 0);
        run_angle(89,  1'b0, 1'b0, -1, 0, 0);
        run_angle(90,  1'b0, 1'b0, -1, 0, 0);
        // Wait and stall delay
        run_angle(60,  1'b0, 1'b0, -1, 5, 3);
        // Reset during scan of line 1, then a fresh angle
        run_angle(20,  1'b0, 1'b0, 1, 0, 0);
        run_angle(10,  1'b0, 1'b0, -1, 0, 0);
        // Valid held high: back-to-back accepts, angle >= 180
        run_angle(70,  1'b0, 1'b1, -1, 0, 0);
        run_angle(170, 1'b0, 1'b1, -1, 0, 0);
        run_angle(200, 1'b0, 1'b0, -1, 0, 0);
        // Randomized angles, waits, stalls and ignored inputs
        for (int i = 0; i < 8; i++) begin
            run_angle(int'($urandom_range(0, 255)), 1'b1, 1'(i % 2), -1, 0, 0);
        end
        hs_angle_valid = 1'b0;
        @(negedge clk);
        out_chk(0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
